// File: rtl/multidigit_counter.sv
// Multi-digit hex/BCD up/down counter with synchronised STEP input,
// parallel load, wrap/saturate limits and per-digit seven-segment outputs.

module hexunit (
   input  logic [3:0] digit,
   output logic [6:0] seg
);
   // Active-high segments, bit order gfedcba
   always_comb begin
      seg = 7'h00;
      unique case (digit)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
      endcase
   end
endmodule

module multidigit_counter #(
   parameter int DIGITS   = 4,
   parameter int BCD      = 0,
   parameter int SATURATE = 0
) (
   input  logic                  CLK,
   input  logic                  CLR_N,
   input  logic                  STEP,
   input  logic                  EN,
   input  logic                  UP,
   input  logic                  LD,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  TC,
   output logic                  OVF,
   output logic [7*DIGITS-1:0]   HEX
);
   localparam int W = 4*DIGITS;
   localparam logic [W-1:0] MAX_VAL = (BCD != 0) ? {DIGITS{4'h9}} : {W{1'b1}};

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;
   logic [W-1:0] q_q, q_d;
   logic ovf_q, ovf_d;
   logic step_pulse, do_count, at_max, at_min;

   logic [DIGITS-1:0][3:0] inc_v, dec_v, ld_v;
   logic carry, borrow;

   assign s1_d       = STEP;
   assign s2_d       = s1_q;
   assign s3_d       = s2_q;
   assign step_pulse = s2_q & ~s3_q;
   assign do_count   = step_pulse & EN & ~LD;
   assign at_max     = (q_q == MAX_VAL);
   assign at_min     = (q_q == '0);

   // Digit-wise ripple; at the limits it naturally wraps to MIN/MAX
   always_comb begin
      inc_v  = q_q;
      dec_v  = q_q;
      ld_v   = D;
      carry  = 1'b1;
      borrow = 1'b1;
      if (BCD != 0) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
               if (q_q[4*i +: 4] == 4'd9) inc_v[i] = 4'd0;
               else begin
                  inc_v[i] = q_q[4*i +: 4] + 4'd1;
                  carry    = 1'b0;
               end
            end
            if (borrow) begin
               if (q_q[4*i +: 4] == 4'd0) dec_v[i] = 4'd9;
               else begin
                  dec_v[i] = q_q[4*i +: 4] - 4'd1;
                  borrow   = 1'b0;
               end
            end
            if (D[4*i +: 4] > 4'd9) ld_v[i] = 4'd9;
         end
      end else begin
         inc_v = q_q + W'(1);
         dec_v = q_q - W'(1);
      end
   end

   always_comb begin
      q_d   = q_q;
      ovf_d = ovf_q;
      if (LD) begin
         q_d   = ld_v;
         ovf_d = 1'b0;
      end else if (do_count) begin
         if (UP) begin
            if (at_max) ovf_d = 1'b1;
            if (!(at_max && SATURATE != 0)) q_d = inc_v;
         end else begin
            if (at_min) ovf_d = 1'b1;
            if (!(at_min && SATURATE != 0)) q_d = dec_v;
         end
      end
   end

   // Synchroniser resets high so a button held through reset does not count
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         s1_q  <= 1'b1;
         s2_q  <= 1'b1;
         s3_q  <= 1'b1;
         q_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         s3_q  <= s3_d;
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign Q   = q_q;
   assign OVF = ovf_q;
   assign TC  = UP ? at_max : at_min;

   for (genvar g = 0; g < DIGITS; g++) begin : g_hex
      hexunit u_hex (
         .digit (q_q[4*g +: 4]),
         .seg   (HEX[7*g +: 7])
      );
   end
endmodule

// File: tb/tb_multidigit_counter.sv
// Directed bench: one BCD/wrap counter and one hex/saturate counter on shared inputs.

module tb_multidigit_counter;
   logic        CLK = 1'b0;
   logic        CLR_N, STEP, EN, UP, LD;
   logic [15:0] D;
   logic [15:0] q_b, q_h;
   logic        tc_b, tc_h, ovf_b, ovf_h;
   logic [27:0] hex_b, hex_h;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [27:0] HEX_ZERO = {4{7'h3F}};

   always #5 CLK = ~CLK;

   multidigit_counter #(.DIGITS(4), .BCD(1), .SATURATE(0)) u_bcd (
      .CLK(CLK), .CLR_N(CLR_N), .STEP(STEP), .EN(EN), .UP(UP), .LD(LD), .D(D),
      .Q(q_b), .TC(tc_b), .OVF(ovf_b), .HEX(hex_b)
   );

   multidigit_counter #(.DIGITS(4), .BCD(0), .SATURATE(1)) u_hex (
      .CLK(CLK), .CLR_N(CLR_N), .STEP(STEP), .EN(EN), .UP(UP), .LD(LD), .D(D),
      .Q(q_h), .TC(tc_h), .OVF(ovf_h), .HEX(hex_h)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press();
      STEP = 1'b1;
      cyc(3);
      STEP = 1'b0;
      cyc(3);
   endtask

   task automatic load(input logic [15:0] v);
      LD = 1'b1;
      D  = v;
      cyc(1);
      LD = 1'b0;
   endtask

   initial begin
      CLR_N = 1'b1; STEP = 1'b1; EN = 1'b1; UP = 1'b1; LD = 1'b0; D = '0;
      #2 CLR_N = 1'b0;
      cyc(2);
      // reset with button held
      chk("rst_q", q_h, 0);
      chk("rst_ovf", ovf_h, 0);
      chk("rst_tc_up", tc_h, 0);
      chk("rst_hex", hex_h, HEX_ZERO);
      UP = 1'b0; #1;
      chk("rst_tc_dn", tc_h, 1);
      UP = 1'b1;
      cyc(1);
      CLR_N = 1'b1;
      cyc(10);
      chk("held_q", q_h, 0);
      chk("held_ovf", ovf_h, 0);
      STEP = 1'b0;
      cyc(3);
      STEP = 1'b1;
      cyc(2);
      chk("lat_n1", q_h, 16'h0000);
      cyc(1);
      chk("lat_n2", q_h, 16'h0001);
      STEP = 1'b0;
      cyc(3);

      // BCD carry/borrow and load clamp
      load(16'h0999);
      chk("bcd_ld", q_b, 16'h0999);
      press();
      chk("bcd_carry", q_b, 16'h1000);
      chk("bcd_carry_tc", tc_b, 0);
      UP = 1'b0;
      press();
      chk("bcd_borrow", q_b, 16'h0999);
      load(16'h00AF);
      chk("bcd_clamp", q_b, 16'h0099);
      chk("hex_noclamp", q_h, 16'h00AF);
      chk("bcd_hex", hex_b, {7'h3F, 7'h3F, 7'h6F, 7'h6F});

      // wrap
      load(16'h9999);
      UP = 1'b1;
      press();
      chk("wrap_q", q_b, 16'h0000);
      chk("wrap_ovf", ovf_b, 1);
      chk("wrap_tc", tc_b, 0);
      press();
      chk("wrap_q2", q_b, 16'h0001);
      chk("wrap_ovf2", ovf_b, 1);
      load(16'h1234);
      chk("wrap_ld", q_b, 16'h1234);
      chk("wrap_ld_ovf", ovf_b, 0);

      // saturate
      load(16'h0000);
      UP = 1'b0;
      press(); press(); press();
      chk("sat_q", q_h, 16'h0000);
      chk("sat_ovf", ovf_h, 1);
      chk("sat_tc", tc_h, 1);
      chk("bcd_underwrap", q_b, 16'h9997);
      UP = 1'b1;
      press();
      chk("sat_up", q_h, 16'h0001);
      chk("bcd_up", q_b, 16'h9998);

      // load wins over a same-cycle pulse
      STEP = 1'b1;
      cyc(2);
      LD = 1'b1; D = 16'h0042;
      cyc(1);
      LD = 1'b0;
      cyc(3);
      chk("prio_q", q_h, 16'h0042);
      chk("prio_ovf", ovf_h, 0);
      STEP = 1'b0;
      cyc(3);
      EN = 1'b0;
      repeat (5) press();
      chk("en_off", q_h, 16'h0042);
      EN = 1'b1;
      cyc(5);
      chk("en_noqueue", q_h, 16'h0042);

      // async reset while step_pulse is high
      load(16'h0007);
      STEP = 1'b1;
      cyc(2);
      CLR_N = 1'b0;
      #1;
      chk("amid_q", q_h, 0);
      chk("amid_hex", hex_h, HEX_ZERO);
      chk("amid_hex_b", hex_b, HEX_ZERO);
      cyc(2);
      CLR_N = 1'b1;
      cyc(5);
      chk("amid_after", q_h, 0);
      STEP = 1'b0;
      cyc(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/multidigit_counter.md
# multidigit_counter

Parametrised multi-digit up/down counter that replaces the fixed 16-bit up-counter on the board's pushbutton/switch front end. It counts in hex or BCD, supports parallel load, wrap or saturate at the limits, and reports terminal-count and sticky overflow flags. Unlike the earlier block, it never clocks on button logic. Button presses enter on the `STEP` input, which is synchronised and edge-detected inside the block on the system clock. Each digit drives one seven-segment display through the team's existing `hexunit` decoder.

## Interface
- `DIGITS`, 4: number of 4-bit digits (1–8); count width is `4*DIGITS`.
- `BCD`, 0: 0 = binary/hex counting; 1 = each digit counts 0–9 (decimal).
- `SATURATE`, 0: 0 = wrap at limits; 1 = hold at limits.
- `CLK` input 1: system clock; all state changes on the rising edge.
- `CLR_N` input 1: reset, asynchronous, active-low.
- `STEP` input 1: asynchronous count request (button level); one count per rising edge.
- `EN` input 1: count enable, synchronous.
- `UP` input 1: 1 = increment, 0 = decrement.
- `LD` input 1: synchronous parallel load of `D`.
- `D` input 4*DIGITS: load value, digit i at `[4i+3:4i]`.
- `Q` output 4*DIGITS: current count.
- `TC` output 1: terminal count for the current direction.
- `OVF` output 1: sticky overflow/underflow flag.
- `HEX` output 7*DIGITS: segment patterns, digit i at `[7i+6:7i]`, from `hexunit` on Q digit i.

## Operation
- **Limits.** `MAX` = 16^DIGITS−1 when `BCD=0`. `MAX` = 10^DIGITS−1 (all digits 9) when `BCD=1`. `MIN` = 0.
- **Input synchroniser.** `STEP` passes through a 2-flop synchroniser (s1, s2) and then a delay flop s3.
  - `step_pulse` = s2 & ~s3, exactly one cycle wide per `STEP` rising edge.
  - No pulse is produced for a `STEP` falling edge.
- **Priority per edge.** LD > count > hold.
  - `LD=1`: Q <= D, OVF <= 0; any `step_pulse` in the same cycle is discarded.
  - `BCD=1` load: each digit of D greater than 9 is loaded as 9.
- **Count condition.** `step_pulse & EN & ~LD`. `EN=0` discards the pulse; it is not queued.
- **Increment, BCD=1.** Ripple digit-wise: a digit at 9 becomes 0 and carries into the next digit.
- **Decrement, BCD=1.** A digit at 0 becomes 9 and borrows from the next digit.
- **BCD=0.** Plain 4*DIGITS-bit binary add/subtract.
- **At MAX counting up, or MIN counting down:**
  - `SATURATE=0`: Q wraps to MIN (resp. MAX) and OVF <= 1.
  - `SATURATE=1`: Q holds and OVF <= 1.
- **OVF.** Cleared only by reset or LD; once set, it stays set through any further counting.
- **TC.** Combinational from registered Q and live `UP`: `UP ? (Q==MAX) : (Q==MIN)`.
- **Direction change.** `UP` may change any cycle; it takes effect on the next counted pulse.

## Timing
- **Reset values** (`CLR_N` low, immediate, independent of CLK):
  - Q = 0, OVF = 0.
  - s1 = s2 = s3 = 1, so a button held through reset release does not count.
  - TC = 1 if `UP=0`, else 0 (Q=0).
  - HEX = `hexunit`(0) on every digit.
- **STEP latency.** STEP goes high with setup before edge n:
  - s1 = 1 at edge n, s2 = 1 at edge n+1.
  - `step_pulse` is high during the cycle following edge n+1.
  - Q updates at edge n+2.
- **Minimum STEP widths.** High ≥ 2 CLK periods and low ≥ 2 CLK periods guarantee one count per press. Debounce is outside this block.
- **LD latency.** LD sampled at edge n gives Q = D after edge n; OVF is cleared at the same edge.
- **Output latency.** TC and HEX follow Q combinationally, with no added latency.
- **Reset mid-operation.** Asserting `CLR_N` during any pulse or load aborts it; the state is as listed above.
- **Reset release.** On release, the first count requires a fresh STEP 0→1 transition observed by the synchroniser.

## Test plan
- **Reset and held button.** DIGITS=4, BCD=0: hold STEP=1 through CLR_N low→high, then 10 cycles -> Q=0x0000, OVF=0; release STEP and press again -> Q=0x0001 exactly two edges after the STEP rise is first sampled.
- **BCD carry/borrow.** BCD=1, UP=1: LD D=0x0999, one press -> Q=0x1000, TC=0; set UP=0, one press -> Q=0x0999; load D=0x00AF -> Q=0x0099.
- **Wrap.** BCD=1, SATURATE=0: load 0x9999, UP=1, one press -> Q=0x0000, OVF=1, TC=0. Next press -> Q=0x0001, OVF still 1. LD D=0x1234 -> Q=0x1234, OVF=0.
- **Saturate.** BCD=0, SATURATE=1: load 0x0000, UP=0, three presses -> Q=0x0000, OVF=1, TC=1. UP=1, one press -> Q=0x0001.
- **Priority and enable.** A pulse arriving in the same cycle as LD=1 with D=0x0042 -> Q=0x0042, not 0x0043. EN=0 with 5 presses -> Q unchanged. EN=1 afterwards without a new press -> no count.
- **Async reset mid-count.** Assert CLR_N low in the cycle `step_pulse` is high with Q=0x0007 -> Q=0 immediately, no count after release. HEX digits all equal `hexunit`(0).
